// File: rtl/utap_rx.sv
// rtl/utap_rx.sv - serial debug-line byte receiver with receive FIFO; optional even parity via UTAP_RX_PARITY_EN
module utap_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UTAP_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state, state_nxt;
    logic            rx_m, rx_s;
    logic [TW-1:0]   timer, timer_nxt;
    logic [2:0]      idx, idx_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic            par_err, par_err_nxt;
    logic            stop_hit;
    logic            good_byte, bad_frame, full, pop, push, drop;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Receiver state, bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            idx     <= idx_nxt;
            shreg   <= shreg_nxt;
            par_err <= par_err_nxt;
        end
    end

    // Next-state: mid-bit sampling, start sampled at half a bit, data/parity/stop one bit later
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + 1'b1;
        idx_nxt     = idx;
        shreg_nxt   = shreg;
        par_err_nxt = par_err;
        stop_hit    = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt   = '0;
                par_err_nxt = 1'b0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (timer == T_HALF) begin
                    timer_nxt = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == T_FULL) begin
                    timer_nxt = '0;
                    shreg_nxt = {rx_s, shreg[7:1]};
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UTAP_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UTAP_RX_PARITY_EN
            PARITY: begin
                if (timer == T_FULL) begin
                    timer_nxt   = '0;
                    par_err_nxt = rx_s ^ (^shreg);
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (timer == T_FULL) begin
                    timer_nxt = '0;
                    stop_hit  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame outcome and FIFO handshake; a pop in the stop cycle frees room for the new byte
    always_comb begin
        rd_valid  = (fifo_count != '0);
        full      = (fifo_count == DEPTH);
        pop       = rd_valid && rd_ready;
        good_byte = stop_hit && rx_s && !par_err;
        bad_frame = stop_hit && !(rx_s && !par_err);
        push      = good_byte && (!full || pop);
        drop      = good_byte && full && !pop;
        rd_data   = rd_valid ? mem[rd_ptr] : 8'h00;
    end

    // FIFO storage; contents need no reset because rd_data is masked while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    // FIFO pointers, occupancy and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            frame_err  <= bad_frame;
            overrun    <= drop;
        end
    end

endmodule

// File: doc/utap_rx.md
UTAP_RX -- requirements
Module: utap_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, even, legal range 4..1024.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries, a power of two, legal range 2..16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial debug line, idle high.
REQ-006 The block SHALL have port rd_data, output, 8 bits: FIFO head byte.
REQ-007 The block SHALL have port rd_valid, output, 1 bit: FIFO non-empty.
REQ-008 The block SHALL have port rd_ready, input, 1 bit: the downstream consumer (dbgctl) accepts the head byte.
REQ-009 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-012 The block SHALL pass rx through a 2-flop synchroniser (rx_s); all state-machine decisions SHALL use rx_s only.
REQ-013 The state machine SHALL have states IDLE, START, DATA, PARITY (present only with the macro) and STOP, with one bit-timer of $clog2(CLKS_PER_BIT) bits and one 3-bit bit index.
REQ-014 In IDLE, rx_s == 0 SHALL move the FSM to START and clear the timer.
REQ-015 START SHALL sample rx_s when the timer reaches CLKS_PER_BIT/2-1; if rx_s == 1, the FSM SHALL return to IDLE with no pulse (false start); otherwise it SHALL go to DATA and clear the timer.
REQ-016 DATA SHALL sample rx_s each time the timer reaches CLKS_PER_BIT-1, shifting 8 bits in LSB first, then go to PARITY (macro defined) or STOP.
REQ-017 STOP SHALL sample at timer == CLKS_PER_BIT-1 and return to IDLE in the next cycle; IDLE can then detect a new start immediately.
REQ-018 If the stop sample is 0, the block SHALL pulse frame_err, discard the byte, and leave the FIFO unchanged.
REQ-019 If the stop sample is 1 and the FIFO is not full, the block SHALL push the byte; rd_valid/rd_data SHALL reflect it on the next cycle.
REQ-020 If the stop sample is 1 and the FIFO is full with no pop in that cycle, the block SHALL pulse overrun and discard the byte.
REQ-021 With the FIFO full, a push and a pop (rd_valid && rd_ready) in the same cycle SHALL both succeed, and fifo_count SHALL stay at FIFO_DEPTH.
REQ-022 Push and pop on a non-full, non-empty FIFO SHALL leave fifo_count unchanged; a pop on an empty FIFO SHALL be ignored.
REQ-023 rd_data SHALL be stable while rd_valid && !rd_ready.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 frame_err and overrun SHALL never assert in the same cycle and SHALL never last longer than one cycle.

Reset
REQ-026 On reset the block SHALL set the FSM to IDLE, the synchroniser flops to 1, timer/index/pointers to 0, fifo_count=0, rd_valid=0, rd_data=0, frame_err=0 and overrun=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no push and no pulse.
REQ-028 Reset SHALL take priority over a simultaneous push or pop.

Configuration
REQ-029 With macro UTAP_RX_PARITY_EN defined, the block SHALL expect an even-parity bit after bit 7, sampled in state PARITY at timer == CLKS_PER_BIT-1.
REQ-030 With UTAP_RX_PARITY_EN defined, a parity mismatch SHALL pulse frame_err at the stop sample and discard the byte, even if the stop bit is good.
REQ-031 Without UTAP_RX_PARITY_EN, the block SHALL use 8N1 framing, PARITY SHALL not exist, and the frame SHALL be 10 bits.

Verification
REQ-032 Single byte: send 0xA5, 8N1, CLKS_PER_BIT=16 -> rd_valid rises one cycle after the stop sample, rd_data=0xA5, fifo_count=1; rd_ready=1 for one cycle -> fifo_count=0, rd_valid=0.
REQ-033 False start: 3-cycle low glitch on rx -> FSM back in IDLE, no push, no pulse.
REQ-034 Overrun: send 0x01..0x05 with rd_ready=0, FIFO_DEPTH=4 -> fifo_count=4, one overrun pulse on byte 0x05, then pops return 0x01..0x04 in order.
REQ-035 Full + simultaneous pop: FIFO full, rd_ready=1 in the stop-sample cycle of byte 0x77 -> fifo_count stays 4, 0x77 is last out, no overrun.
REQ-036 Framing: send 0x3C with stop bit 0 -> one frame_err pulse, fifo_count unchanged; with UTAP_RX_PARITY_EN, send 0x3C with parity 1 -> frame_err, byte dropped.
REQ-037 Reset mid-frame: reset asserted after bit 3 of 0xFF, then 0x12 sent -> only 0x12 appears in the FIFO, no pulses.
